ssd1306_spi_tx: RTL and testbench
=================================

SSD1306_SPI_TX -- requirements
Module: ssd1306_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning clk_in cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have port clk_in, input, 1, system clock; the only clock.
REQ-003 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-004 SHALL have port data_in, input, 8, byte to transmit, MSB first.
REQ-005 SHALL have port dc_in, input, 1, data/command flag sent with the byte (1 = data).
REQ-006 SHALL have port write_stb_in, input, 1, one-cycle request to send data_in/dc_in.
REQ-007 SHALL have port ready_out, output, 1, high when a strobe will be accepted.
REQ-008 SHALL have port oled_csn_out, output, 1, SPI chip select, active low.
REQ-009 SHALL have port oled_dc_out, output, 1, D/C# pin.
REQ-010 SHALL have port oled_clk_out, output, 1, SCLK.
REQ-011 SHALL have port oled_mosi_out, output, 1, serial data.

Function
REQ-012 SHALL implement states S_IDLE, S_SETUP, S_SHIFT, S_HOLD.
REQ-013 SHALL accept a strobe only when write_stb_in and ready_out are both high in the same cycle; it captures data_in and dc_in into internal registers and enters S_SETUP on the next edge.
REQ-014 SHALL ignore write_stb_in while ready_out is low, with no queuing and no side effects.
REQ-015 SHALL use SPI mode 0: SCLK idles low; MOSI changes only while SCLK is low; the panel samples on the SCLK rising edge.
REQ-016 S_SETUP SHALL drive csn low, dc = captured dc, mosi = bit 7, SCLK low, for CLK_DIV cycles, then enter S_SHIFT.
REQ-017 S_SHIFT SHALL emit 8 bits, each as SCLK high for CLK_DIV cycles then low for CLK_DIV cycles; mosi advances to the next lower bit at each falling edge; after bit 0 falls, enter S_HOLD.
REQ-018 S_HOLD SHALL keep csn low and SCLK low for CLK_DIV cycles, then enter S_IDLE with csn high.
REQ-019 SHALL keep a single byte busy for exactly 18*CLK_DIV cycles, measured from the cycle after acceptance to the first S_IDLE cycle.
REQ-020 ready_out SHALL be high exactly in S_IDLE, except where REQ-026 applies.
REQ-021 oled_dc_out SHALL hold its last transmitted value while idle.
REQ-022 oled_mosi_out SHALL be held low while idle.
REQ-023 SHALL register all outputs, with no combinational path from input to pin.
REQ-024 SHALL use a half-period counter of width $clog2(CLK_DIV+1) and a 3-bit bit counter; both wrap to 0 on phase/state exit.

Reset
REQ-025 While reset_in is high, on each clk_in edge the block SHALL enter S_IDLE and force csn=1, clk=0, mosi=0, dc=0, ready_out=1; a transfer in progress is aborted with no partial completion, and csn rises on the first reset edge.

Configuration
REQ-026 With OLED_SPI_BURST_EN defined:
- ready_out SHALL also be high throughout S_HOLD.
- A strobe accepted in S_HOLD SHALL enter S_SHIFT directly on the next edge, with csn kept low, the new dc and bit 7 driven, and S_IDLE/S_SETUP skipped.
- Back-to-back byte period is therefore 17*CLK_DIV.
- A strobe in S_IDLE behaves per REQ-013.
REQ-027 Without OLED_SPI_BURST_EN, ready_out SHALL be low in S_HOLD and csn SHALL return high between every byte.

Structure
REQ-028 Package ssd1306_pkg SHALL hold the state enum e_spi_state and localparams SPI_BITS=8 and SPI_BYTE_HALFPERIODS=16; they are shared with ssd1306_driver.
REQ-029 Sub-module spi_halfperiod_tick (CLK_DIV-cycle tick generator, restartable) SHALL be the single instantiated child; all other logic is inline.

Verification
REQ-030 Reset then idle, CLK_DIV=1: pins csn=1, clk=0, mosi=0, dc=0, ready=1 held for 20 cycles.
REQ-031 CLK_DIV=1, strobe 0xA5, dc=1: SPI monitor captures 0xA5 with dc=1 on 8 rising edges; ready is low for exactly 18 cycles; csn is low for 18 cycles.
REQ-032 CLK_DIV=3, strobe 0x3C, dc=0: SCLK high/low widths are 3 cycles each; busy time is 54 cycles; the byte decodes as 0x3C.
REQ-033 Strobe 0xFF, then strobe 0x00 five cycles later (ignored): only 0xFF is transmitted; a second strobe after ready rises sends 0x00.
REQ-034 Reset asserted mid-transfer, at bit 4 of 0x81: csn=1 and clk=0 on the next edge; a later strobe 0x81 transmits cleanly.
REQ-035 OLED_SPI_BURST_EN, CLK_DIV=1, strobes 0x12, 0x34, 0x56 each issued on the first ready cycle: csn stays low continuously, all three bytes decode correctly, byte period is 17 cycles; without the macro, csn pulses high between bytes.

Source files
------------

// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 SPI link (transmitter and panel driver).
package ssd1306_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } e_spi_state;

  localparam int SPI_BITS             = 8;
  localparam int SPI_BYTE_HALFPERIODS = 16;

endpackage

// File: rtl/spi_halfperiod_tick.sv
// Restartable CLK_DIV-cycle tick generator: tick_o is high on the last cycle of each half-period.
module spi_halfperiod_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for an SSD1306 panel, all pins registered.
// Optional OLED_SPI_BURST_EN: accept the next byte during S_HOLD and chain it without releasing csn.
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] data_in,
  input  logic       dc_in,
  input  logic       write_stb_in,
  output logic       ready_out,
  output logic       oled_csn_out,
  output logic       oled_dc_out,
  output logic       oled_clk_out,
  output logic       oled_mosi_out
);

  e_spi_state state_q, state_d;
  logic       csn_q, csn_d, dc_q, dc_d, sclk_q, sclk_d, mosi_q, mosi_d, ready_q, ready_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       tick, restart, accept;

  spi_halfperiod_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i    (clk_in),
    .rst_i    (reset_in),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign accept = write_stb_in & ready_q;

  always_comb begin
    state_d = state_q;
    csn_d   = csn_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        restart = 1'b1;
        if (accept) begin
          state_d = S_SETUP;
          csn_d   = 1'b0;
          dc_d    = dc_in;
          sh_d    = data_in;
          mosi_d  = data_in[7];
          sclk_d  = 1'b0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next lower bit while SCLK is low.
            sclk_d = 1'b0;
            sh_d   = {sh_q[6:0], 1'b0};
            mosi_d = sh_q[6];
          end else if (bit_q == 3'(SPI_BITS - 1)) begin
            state_d = S_HOLD;
            bit_d   = '0;
          end else begin
            bit_d  = bit_q + 3'd1;
            sclk_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_IDLE;
          csn_d   = 1'b1;
          mosi_d  = 1'b0;
        end
`ifdef OLED_SPI_BURST_EN
        if (accept) begin
          state_d = S_SHIFT;
          restart = 1'b1;
          csn_d   = 1'b0;
          dc_d    = dc_in;
          sh_d    = data_in;
          mosi_d  = data_in[7];
          sclk_d  = 1'b1;
          bit_d   = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef OLED_SPI_BURST_EN
    ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
`else
    ready_d = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      csn_q   <= 1'b1;
      dc_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk_in) sh_q <= sh_d;

  assign ready_out     = ready_q;
  assign oled_csn_out  = csn_q;
  assign oled_dc_out   = dc_q;
  assign oled_clk_out  = sclk_q;
  assign oled_mosi_out = mosi_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Directed bench for ssd1306_spi_tx: two instances (CLK_DIV=1 and CLK_DIV=3) with a cycle-level SPI monitor.
module tb_ssd1306_spi_tx;

`ifdef OLED_SPI_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       dc = 1'b0;
  logic       stb_a = 1'b0, stb_b = 1'b0;
  logic       rdy_a, csn_a, dco_a, sck_a, mosi_a;
  logic       rdy_b, csn_b, dco_b, sck_b, mosi_b;

  ssd1306_spi_tx #(.CLK_DIV(1)) u_a (
    .clk_in(clk), .reset_in(rst), .data_in(data), .dc_in(dc), .write_stb_in(stb_a),
    .ready_out(rdy_a), .oled_csn_out(csn_a), .oled_dc_out(dco_a),
    .oled_clk_out(sck_a), .oled_mosi_out(mosi_a)
  );

  ssd1306_spi_tx #(.CLK_DIV(3)) u_b (
    .clk_in(clk), .reset_in(rst), .data_in(data), .dc_in(dc), .write_stb_in(stb_b),
    .ready_out(rdy_b), .oled_csn_out(csn_b), .oled_dc_out(dco_b),
    .oled_clk_out(sck_b), .oled_mosi_out(mosi_b)
  );

  int checks = 0;
  int failures = 0;

  logic [23:0] cap;
  int rises, busy, csn_low, dc_ones, hi_min, hi_max, lo_min, lo_max;
  bit timeout;

  // {ready, csn, dc, sclk, mosi}
  function automatic logic [4:0] pins(input int sel);
    if (sel == 0) return {rdy_a, csn_a, dco_a, sck_a, mosi_a};
    return {rdy_b, csn_b, dco_b, sck_b, mosi_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one byte and monitor the pins until csn returns high (or abort after N rises).
  task automatic xfer(input int sel, input logic [7:0] d, input logic dcv, input int ign_off,
                      input logic [7:0] ign_d, input int abort_rises, input int budget);
    logic [4:0] p;
    logic prev;
    int hi, lo, n;
    cap = '0; rises = 0; busy = 0; csn_low = 0; dc_ones = 0; timeout = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    prev = 1'b0; hi = 0; lo = 0; n = 0;
    data = d; dc = dcv;
    if (sel == 0) stb_a = 1'b1; else stb_b = 1'b1;
    tick();
    stb_a = 1'b0; stb_b = 1'b0;
    p = pins(sel);
    while (p[3] == 1'b0 && n < budget) begin
      csn_low++;
      if (!p[4]) busy++;
      if (p[1]) begin
        hi++;
        if (!prev) begin
          if (rises > 0) begin
            if (lo < lo_min) lo_min = lo;
            if (lo > lo_max) lo_max = lo;
          end
          lo = 0;
          rises++;
          cap = {cap[22:0], p[0]};
          if (p[2]) dc_ones++;
        end
      end else begin
        if (prev) begin
          if (hi < hi_min) hi_min = hi;
          if (hi > hi_max) hi_max = hi;
          hi = 0;
        end
        if (rises > 0) lo++;
      end
      prev = p[1];
      if (abort_rises > 0 && rises == abort_rises) break;
      if (n == ign_off) begin
        data = ign_d; dc = ~dcv;
        if (sel == 0) stb_a = 1'b1; else stb_b = 1'b1;
      end
      n++;
      tick();
      stb_a = 1'b0; stb_b = 1'b0;
      p = pins(sel);
    end
    if (n >= budget) timeout = 1;
  endtask

  task automatic test_reset();
    logic [4:0] p;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      p = pins(0);
      checks++;
      if (p !== 5'b11000) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d pins(rdy,csn,dc,clk,mosi)=%b expected=11000", i, p);
      end
    end
    p = pins(1);
    checks++;
    if (p !== 5'b11000) begin
      failures++;
      $display("FAIL reset_idle_div3 pins=%b expected=11000", p);
    end
  endtask

  task automatic test_byte_a5();
    logic [4:0] p;
    xfer(0, 8'hA5, 1'b1, -1, 8'h00, 0, 100);
    checks++;
    if (timeout || cap[7:0] !== 8'hA5 || rises != 8) begin
      failures++;
      $display("FAIL a5_data got=%h rises=%0d timeout=%0d expected=a5 rises=8", cap[7:0], rises, timeout);
    end
    checks++;
    if (dc_ones != 8) begin
      failures++;
      $display("FAIL a5_dc dc_high_at_rises=%0d expected=8", dc_ones);
    end
    checks++;
    if (busy != 18 - BURST) begin
      failures++;
      $display("FAIL a5_ready_low got=%0d expected=%0d", busy, 18 - BURST);
    end
    checks++;
    if (csn_low != 18) begin
      failures++;
      $display("FAIL a5_csn_low got=%0d expected=18", csn_low);
    end
    checks++;
    if (hi_min != 1 || hi_max != 1) begin
      failures++;
      $display("FAIL a5_sclk_high min=%0d max=%0d expected=1", hi_min, hi_max);
    end
    p = pins(0);
    checks++;
    if (p !== 5'b11100) begin
      failures++;
      $display("FAIL a5_idle_after pins=%b expected=11100", p);
    end
  endtask

  task automatic test_div3();
    xfer(1, 8'h3C, 1'b0, -1, 8'h00, 0, 200);
    checks++;
    if (timeout || cap[7:0] !== 8'h3C || rises != 8) begin
      failures++;
      $display("FAIL div3_data got=%h rises=%0d timeout=%0d expected=3c rises=8", cap[7:0], rises, timeout);
    end
    checks++;
    if (busy != 3 * (18 - BURST) || csn_low != 54) begin
      failures++;
      $display("FAIL div3_busy ready_low=%0d csn_low=%0d expected=%0d/54", busy, csn_low, 3 * (18 - BURST));
    end
    checks++;
    if (hi_min != 3 || hi_max != 3 || lo_min != 3 || lo_max != 3) begin
      failures++;
      $display("FAIL div3_widths hi=%0d..%0d lo=%0d..%0d expected=3", hi_min, hi_max, lo_min, lo_max);
    end
    checks++;
    if (dc_ones != 0) begin
      failures++;
      $display("FAIL div3_dc dc_high_at_rises=%0d expected=0", dc_ones);
    end
  endtask

  task automatic test_ignore();
    logic [4:0] p;
    xfer(0, 8'hFF, 1'b1, 4, 8'h00, 0, 100);
    checks++;
    if (timeout || cap[7:0] !== 8'hFF || rises != 8 || busy != 18 - BURST) begin
      failures++;
      $display("FAIL ignore_first got=%h rises=%0d busy=%0d expected=ff 8 %0d", cap[7:0], rises, busy, 18 - BURST);
    end
    repeat (5) tick();
    p = pins(0);
    checks++;
    if (p !== 5'b11100) begin
      failures++;
      $display("FAIL ignore_no_queue pins=%b expected=11100", p);
    end
    xfer(0, 8'h00, 1'b0, -1, 8'h00, 0, 100);
    checks++;
    if (timeout || cap[7:0] !== 8'h00 || rises != 8 || dc_ones != 0) begin
      failures++;
      $display("FAIL ignore_second got=%h rises=%0d dc_ones=%0d expected=00 8 0", cap[7:0], rises, dc_ones);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] p;
    xfer(0, 8'h81, 1'b1, -1, 8'h00, 4, 100);
    checks++;
    if (rises != 4 || pins(0) !== 5'b00110) begin
      failures++;
      $display("FAIL midreset_reach rises=%0d pins=%b expected=4 00110", rises, pins(0));
    end
    rst = 1'b1;
    tick();
    p = pins(0);
    checks++;
    if (p !== 5'b11000) begin
      failures++;
      $display("FAIL midreset_abort pins=%b expected=11000", p);
    end
    rst = 1'b0;
    repeat (3) tick();
    p = pins(0);
    checks++;
    if (p !== 5'b11000) begin
      failures++;
      $display("FAIL midreset_stays_idle pins=%b expected=11000", p);
    end
    xfer(0, 8'h81, 1'b1, -1, 8'h00, 0, 100);
    checks++;
    if (timeout || cap[7:0] !== 8'h81 || rises != 8 || csn_low != 18 || dc_ones != 8) begin
      failures++;
      $display("FAIL midreset_resend got=%h rises=%0d csn_low=%0d dc_ones=%0d expected=81 8 18 8",
               cap[7:0], rises, csn_low, dc_ones);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic       dcs_in [3];
    logic [2:0] dcs;
    logic [4:0] p;
    logic prev;
    int issued, n, r1, r9, r17, csn_hi, rcnt;
    bytes = '{8'h12, 8'h34, 8'h56};
    dcs_in = '{1'b0, 1'b1, 1'b0};
    cap = '0; dcs = '0; prev = 1'b0; rcnt = 0; n = 0; csn_hi = 0; r1 = -1; r9 = -1; r17 = -1;
    data = bytes[0]; dc = dcs_in[0]; stb_a = 1'b1; issued = 1;
    tick();
    stb_a = 1'b0;
    while (rcnt < 24 && n < 200) begin
      p = pins(0);
      if (p[1] && !prev) begin
        rcnt++;
        cap = {cap[22:0], p[0]};
        if (rcnt == 1)  r1 = n;
        if (rcnt == 9)  r9 = n;
        if (rcnt == 17) r17 = n;
        if (rcnt == 1 || rcnt == 9 || rcnt == 17) dcs = {dcs[1:0], p[2]};
      end
      if (rcnt >= 1 && p[3]) csn_hi++;
      prev = p[1];
      if (p[4] && issued < 3) begin
        data = bytes[issued]; dc = dcs_in[issued]; stb_a = 1'b1; issued++;
      end
      n++;
      tick();
      stb_a = 1'b0;
    end
    checks++;
    if (n >= 200 || cap !== 24'h123456) begin
      failures++;
      $display("FAIL b2b_data got=%h rises=%0d expected=123456 rises=24", cap, rcnt);
    end
    checks++;
    if (dcs !== 3'b010) begin
      failures++;
      $display("FAIL b2b_dc got=%b expected=010", dcs);
    end
    checks++;
    if (r9 - r1 != 19 - 2 * BURST || r17 - r9 != 19 - 2 * BURST) begin
      failures++;
      $display("FAIL b2b_period got=%0d,%0d expected=%0d", r9 - r1, r17 - r9, 19 - 2 * BURST);
    end
    checks++;
    if (csn_hi != 2 - 2 * BURST) begin
      failures++;
      $display("FAIL b2b_csn_gaps csn_high_cycles=%0d expected=%0d", csn_hi, 2 - 2 * BURST);
    end
    n = 0;
    while (pins(0) !== 5'b11000 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (pins(0) !== 5'b11000) begin
      failures++;
      $display("FAIL b2b_final_idle pins=%b expected=11000", pins(0));
    end
  endtask

  initial begin
    test_reset();
    test_byte_a5();
    test_div3();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
